// File: rtl/syn_down_counter_ld_if.sv
// rtl/syn_down_counter_ld_if.sv - control and status bundle for syn_down_counter_ld
//
// Purpose: groups the counter's control inputs and status outputs so the
//          controller and the counter share one typed port.
// Signals:
//   en    count enable, one decrement per enabled cycle while counting
//   load  load strobe, captures D on the clock edge
//   D     start / reload value (BITS wide)
//   Q     current count (BITS wide, registered in the counter)
//   busy  counter is in its counting state
//   done  one-cycle pulse when the count first shows zero
//   zero  Q == 0, combinational
// Modports: master drives en/load/D; slave is the counter.

interface syn_down_counter_ld_if #(
    parameter int BITS = 4
);
    logic            en;
    logic            load;
    logic [BITS-1:0] D;
    logic [BITS-1:0] Q;
    logic            busy;
    logic            done;
    logic            zero;

    modport master (
        output en,
        output load,
        output D,
        input  Q,
        input  busy,
        input  done,
        input  zero
    );

    modport slave (
        input  en,
        input  load,
        input  D,
        output Q,
        output busy,
        output done,
        output zero
    );
endinterface

// File: rtl/syn_down_counter_ld.sv
// rtl/syn_down_counter_ld.sv - loadable synchronous down counter / countdown timer
//
// Purpose: load a start value, decrement once per enabled cycle, pulse done
//          for one cycle when the count reaches zero. Never wraps below zero.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    syn_down_counter_ld_if.slave (en, load, D, Q, busy, done, zero)
// Parameter:
//   BITS   width of counter, load value and Q
// Build option:
//   SYN_DOWN_CNT_AUTO_RELOAD_EN - when defined, the counter stays busy after
//   reaching zero and the next enabled cycle reloads the last loaded value,
//   giving a period of N+1 enabled cycles. Undefined gives one-shot behaviour.

module syn_down_counter_ld #(
    parameter int BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    syn_down_counter_ld_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t          state;
    logic [BITS-1:0] q_r;
    logic            busy_r;
    logic            done_r;

`ifdef SYN_DOWN_CNT_AUTO_RELOAD_EN
    // Reload value is only needed when the counter restarts itself.
    logic [BITS-1:0] reload_r;
`endif

    // Priority: reset > load > en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            q_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SYN_DOWN_CNT_AUTO_RELOAD_EN
            reload_r <= '0;
`endif
        end else if (bus.load) begin
            // A load always wins, aborting any count in flight without a done.
            q_r <= bus.D;
`ifdef SYN_DOWN_CNT_AUTO_RELOAD_EN
            reload_r <= bus.D;
`endif
            if (bus.D != '0) begin
                state  <= S_COUNT;
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end else begin
                // Loading zero is an immediate expiry: one done pulse, not busy.
                state  <= S_EXPIRED;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end else begin
            case (state)
                S_COUNT: begin
                    if (bus.en) begin
                        if (q_r > BITS'(1)) begin
                            q_r    <= q_r - BITS'(1);
                            done_r <= 1'b0;
                        end else if (q_r == BITS'(1)) begin
                            q_r    <= '0;
                            done_r <= 1'b1;
`ifndef SYN_DOWN_CNT_AUTO_RELOAD_EN
                            state  <= S_EXPIRED;
                            busy_r <= 1'b0;
`endif
                        end else begin
                            // Q == 0 while still counting only happens in
                            // auto-reload mode: restart the period.
`ifdef SYN_DOWN_CNT_AUTO_RELOAD_EN
                            q_r <= reload_r;
`endif
                            done_r <= 1'b0;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                S_EXPIRED: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q    = q_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.zero = (q_r == '0);

endmodule
